// File: rtl/cart_pkg.sv
// Shared constants for the cartridge header loader: logo bytes, header
// offsets, the loader state encoding and the Mega Duck mapper code.
package cart_pkg;

  // Reference logo, first byte (header offset 0x104) in the top byte.
  localparam int unsigned LOGO_LEN = 48;
  localparam logic [8*LOGO_LEN-1:0] LOGO =
    384'hCEED6666CC0D000B03730083000C000D_0008111F8889000EDCCC6EE6DDDDD999_BBBB67636E0EECCCDDDC999FBBB9333E;

  // Number of leading logo bytes kept for the multicart comparison.
  localparam int unsigned BUF_LEN = 16;

  // Header byte offsets.
  localparam int unsigned HDR_MD_TYPE = 'h100;
  localparam int unsigned HDR_LOGO_LO = 'h104;
  localparam int unsigned HDR_BUF_HI  = 'h113;
  localparam int unsigned HDR_LOGO_HI = 'h133;
  localparam int unsigned HDR_CHK_LO  = 'h134;
  localparam int unsigned HDR_CGB     = 'h143;
  localparam int unsigned HDR_SGB     = 'h146;
  localparam int unsigned HDR_TYPE    = 'h147;
  localparam int unsigned HDR_ROM     = 'h148;
  localparam int unsigned HDR_RAM     = 'h149;
  localparam int unsigned HDR_OLDLIC  = 'h14B;
  localparam int unsigned HDR_CHK_HI  = 'h14C;
  localparam int unsigned HDR_CHKSUM  = 'h14D;

  localparam logic [7:0] MEGADUCK_TYPE = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Logo byte at position idx (0 = header offset 0x104).
  function automatic logic [7:0] logo_byte(input logic [5:0] idx);
    return LOGO[8*(LOGO_LEN - 1 - 32'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/ioctl_handshake.sv
// Write handshake for the ioctl download bus: a WR_LAT-deep delay line turns
// an accepted write into a one-cycle dn_write pulse while holding ioctl_wait.
module ioctl_handshake #(
  parameter int unsigned WR_LAT = 1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  input  logic ioctl_wr,
  output logic accept,
  output logic ioctl_wait,
  output logic dn_write,
  output logic cart_ready,
  output logic overrun
);

  logic [WR_LAT-1:0] stage_reg;
  logic              pulse_next;

  // Busy for as long as a write is travelling through the delay line.
  assign ioctl_wait = |stage_reg;
  assign accept     = ioctl_wr & ~ioctl_wait;
  assign dn_write   = stage_reg[WR_LAT-1];

  generate
    if (WR_LAT == 1) begin : g_lat_one
      assign pulse_next = accept;

      // Single-stage delay line.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) stage_reg <= '0;
        else          stage_reg <= accept;
      end
    end else begin : g_lat_many
      assign pulse_next = stage_reg[WR_LAT-2];

      // Shift the accepted write towards the dn_write tap.
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) stage_reg <= '0;
        else          stage_reg <= {stage_reg[WR_LAT-2:0], accept};
      end
    end
  endgenerate

  // Sticky status: ready rises with the first pulse, overrun on a dropped write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_ready <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      cart_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (pulse_next)            cart_ready <= 1'b1;
      if (ioctl_wr && ioctl_wait) overrun   <= 1'b1;
    end
  end

endmodule

// File: rtl/cart_header_loader.sv
// Cartridge download front-end: handshakes ioctl writes, parses the header
// bytes, accumulates the header checksum, checks the logo and detects MBC1
// multicarts from a second logo copy.
module cart_header_loader
  import cart_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned MASK_W  = 9,
  parameter int unsigned WR_LAT  = 1,
  parameter int unsigned M1M_OFS = 'h40000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cart_download,
  input  logic              megaduck,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              dn_write,
  output logic              cart_ready,
  output logic [7:0]        mbc_type,
  output logic [7:0]        rom_size,
  output logic [7:0]        ram_size,
  output logic [7:0]        sgb_flag,
  output logic [7:0]        old_licensee,
  output logic              cgb_flag,
  output logic [MASK_W-1:0] rom_mask,
  output logic              hdr_chk_ok,
  output logic              logo_ok,
  output logic              mbc1m,
  output logic              overrun,
  output logic              hdr_valid
);

  localparam int LANES = int'(DATA_W / 8);

  localparam logic [ADDR_W-1:0] A_MD_TYPE  = ADDR_W'(HDR_MD_TYPE);
  localparam logic [ADDR_W-1:0] A_LOGO_LO  = ADDR_W'(HDR_LOGO_LO);
  localparam logic [ADDR_W-1:0] A_BUF_HI   = ADDR_W'(HDR_BUF_HI);
  localparam logic [ADDR_W-1:0] A_LOGO_HI  = ADDR_W'(HDR_LOGO_HI);
  localparam logic [ADDR_W-1:0] A_CHK_LO   = ADDR_W'(HDR_CHK_LO);
  localparam logic [ADDR_W-1:0] A_CHK_HI   = ADDR_W'(HDR_CHK_HI);
  localparam logic [ADDR_W-1:0] A_CHKSUM   = ADDR_W'(HDR_CHKSUM);
  localparam logic [ADDR_W-1:0] A_CGB      = ADDR_W'(HDR_CGB);
  localparam logic [ADDR_W-1:0] A_SGB      = ADDR_W'(HDR_SGB);
  localparam logic [ADDR_W-1:0] A_TYPE     = ADDR_W'(HDR_TYPE);
  localparam logic [ADDR_W-1:0] A_ROM      = ADDR_W'(HDR_ROM);
  localparam logic [ADDR_W-1:0] A_RAM      = ADDR_W'(HDR_RAM);
  localparam logic [ADDR_W-1:0] A_OLDLIC   = ADDR_W'(HDR_OLDLIC);
  localparam logic [ADDR_W-1:0] A_M1M_LO   = ADDR_W'(M1M_OFS + HDR_LOGO_LO);
  localparam logic [ADDR_W-1:0] A_M1M_BHI  = ADDR_W'(M1M_OFS + HDR_BUF_HI);
  localparam logic [ADDR_W-1:0] A_M1M_HI   = ADDR_W'(M1M_OFS + HDR_LOGO_HI);

  state_t state_reg, state_next;
  logic   dl_q_reg;
  logic   dl_rise, dl_fall;
  logic   start_clear, do_check;
  logic   accept;

  logic [ADDR_W-1:0] lane_addr [LANES];
  logic [7:0]        lane_data [LANES];

  logic [7:0]        chk_reg, chk_next;
  logic [7:0]        chksum_reg, chksum_next;
  logic [7:0]        mbc_type_reg, mbc_type_next;
  logic [7:0]        rom_size_reg, rom_size_next;
  logic [7:0]        ram_size_reg, ram_size_next;
  logic [7:0]        sgb_flag_reg, sgb_flag_next;
  logic [7:0]        old_lic_reg, old_lic_next;
  logic              cgb_flag_reg, cgb_flag_next;
  logic [MASK_W-1:0] rom_mask_reg, rom_mask_next;
  logic              hdr_chk_ok_reg, hdr_chk_ok_next;
  logic              logo_ok_reg, logo_ok_next;
  logic              mbc1m_reg, mbc1m_next;
  logic              m1m_seen_reg, m1m_seen_next;
  logic              md_reg, md_next;
  logic [7:0]        logo_buf_reg [BUF_LEN];
  logic [7:0]        logo_buf_next [BUF_LEN];

  // Byte lanes: the low lane is the (even) bus address, higher lanes follow.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_addr[gi] = ioctl_addr | ADDR_W'(gi);
      assign lane_data[gi] = ioctl_dout[8*gi +: 8];
    end
  endgenerate

  ioctl_handshake #(
    .WR_LAT (WR_LAT)
  ) u_handshake (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .clear      (start_clear),
    .ioctl_wr   (ioctl_wr),
    .accept     (accept),
    .ioctl_wait (ioctl_wait),
    .dn_write   (dn_write),
    .cart_ready (cart_ready),
    .overrun    (overrun)
  );

  assign dl_rise = cart_download & ~dl_q_reg;
  assign dl_fall = ~cart_download & dl_q_reg;

  // State register and download-window edge detector.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      dl_q_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dl_q_reg  <= cart_download;
    end
  end

  // Next state, plus the one-cycle clear and check strobes.
  always_comb begin
    state_next  = state_reg;
    start_clear = 1'b0;
    do_check    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (dl_rise) begin
          start_clear = 1'b1;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (dl_fall) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        do_check   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (dl_rise) begin
          start_clear = 1'b1;
          state_next  = ST_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Header parse: a download start clears everything and wins over a write in
  // the same cycle; otherwise each accepted lane is processed in address order.
  always_comb begin
    chk_next        = chk_reg;
    chksum_next     = chksum_reg;
    mbc_type_next   = mbc_type_reg;
    rom_size_next   = rom_size_reg;
    ram_size_next   = ram_size_reg;
    sgb_flag_next   = sgb_flag_reg;
    old_lic_next    = old_lic_reg;
    cgb_flag_next   = cgb_flag_reg;
    rom_mask_next   = rom_mask_reg;
    hdr_chk_ok_next = hdr_chk_ok_reg;
    logo_ok_next    = logo_ok_reg;
    mbc1m_next      = mbc1m_reg;
    m1m_seen_next   = m1m_seen_reg;
    md_next         = md_reg;
    logo_buf_next   = logo_buf_reg;

    if (start_clear) begin
      chk_next        = 8'h00;
      chksum_next     = 8'h00;
      mbc_type_next   = 8'h00;
      rom_size_next   = 8'h00;
      ram_size_next   = 8'h00;
      sgb_flag_next   = 8'h00;
      old_lic_next    = 8'h00;
      cgb_flag_next   = 1'b0;
      rom_mask_next   = '0;
      hdr_chk_ok_next = 1'b0;
      logo_ok_next    = 1'b1;
      mbc1m_next      = 1'b1;
      m1m_seen_next   = 1'b0;
      md_next         = megaduck;
    end else begin
      if (accept) begin
        // Out-of-range address bits simply fall off the mask.
        rom_mask_next = rom_mask_reg | ioctl_addr[14+MASK_W-1:14];
        for (int l = 0; l < LANES; l++) begin
          if (md_reg) begin
            if (lane_addr[l] > A_MD_TYPE) mbc_type_next = MEGADUCK_TYPE;
          end else begin
            if (lane_addr[l] >= A_CHK_LO && lane_addr[l] <= A_CHK_HI)
              chk_next = chk_next - lane_data[l] - 8'd1;
            case (lane_addr[l])
              A_CGB:    cgb_flag_next = lane_data[l][7];
              A_SGB:    sgb_flag_next = lane_data[l];
              A_TYPE:   mbc_type_next = lane_data[l];
              A_ROM:    rom_size_next = lane_data[l];
              A_RAM:    ram_size_next = lane_data[l];
              A_OLDLIC: old_lic_next  = lane_data[l];
              A_CHKSUM: chksum_next   = lane_data[l];
              default:  ;
            endcase
            if (lane_addr[l] >= A_LOGO_LO && lane_addr[l] <= A_LOGO_HI) begin
              if (lane_data[l] != logo_byte(6'(lane_addr[l] - A_LOGO_LO)))
                logo_ok_next = 1'b0;
            end
          end
          if (lane_addr[l] >= A_LOGO_LO && lane_addr[l] <= A_BUF_HI)
            logo_buf_next[4'(lane_addr[l] - A_LOGO_LO)] = lane_data[l];
          if (lane_addr[l] >= A_M1M_LO && lane_addr[l] <= A_M1M_HI)
            m1m_seen_next = 1'b1;
          if (lane_addr[l] >= A_M1M_LO && lane_addr[l] <= A_M1M_BHI) begin
            if (lane_data[l] != logo_buf_reg[4'(lane_addr[l] - A_M1M_LO)])
              mbc1m_next = 1'b0;
          end
        end
      end
      // Final verdicts; Mega Duck carts carry no checksum or logo to verify.
      if (do_check) begin
        hdr_chk_ok_next = md_reg ? 1'b1 : (chk_next == chksum_next);
        if (md_reg)         logo_ok_next = 1'b1;
        if (!m1m_seen_next) mbc1m_next   = 1'b0;
      end
    end
  end

  // Header registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      chk_reg        <= 8'h00;
      chksum_reg     <= 8'h00;
      mbc_type_reg   <= 8'h00;
      rom_size_reg   <= 8'h00;
      ram_size_reg   <= 8'h00;
      sgb_flag_reg   <= 8'h00;
      old_lic_reg    <= 8'h00;
      cgb_flag_reg   <= 1'b0;
      rom_mask_reg   <= '0;
      hdr_chk_ok_reg <= 1'b0;
      logo_ok_reg    <= 1'b0;
      mbc1m_reg      <= 1'b0;
      m1m_seen_reg   <= 1'b0;
      md_reg         <= 1'b0;
      logo_buf_reg   <= '{default: 8'h00};
    end else begin
      chk_reg        <= chk_next;
      chksum_reg     <= chksum_next;
      mbc_type_reg   <= mbc_type_next;
      rom_size_reg   <= rom_size_next;
      ram_size_reg   <= ram_size_next;
      sgb_flag_reg   <= sgb_flag_next;
      old_lic_reg    <= old_lic_next;
      cgb_flag_reg   <= cgb_flag_next;
      rom_mask_reg   <= rom_mask_next;
      hdr_chk_ok_reg <= hdr_chk_ok_next;
      logo_ok_reg    <= logo_ok_next;
      mbc1m_reg      <= mbc1m_next;
      m1m_seen_reg   <= m1m_seen_next;
      md_reg         <= md_next;
      logo_buf_reg   <= logo_buf_next;
    end
  end

  assign mbc_type     = mbc_type_reg;
  assign rom_size     = rom_size_reg;
  assign ram_size     = ram_size_reg;
  assign sgb_flag     = sgb_flag_reg;
  assign old_licensee = old_lic_reg;
  assign cgb_flag     = cgb_flag_reg;
  assign rom_mask     = rom_mask_reg;
  assign hdr_chk_ok   = hdr_chk_ok_reg;
  assign logo_ok      = logo_ok_reg;
  assign mbc1m        = mbc1m_reg;
  assign hdr_valid    = (state_reg == ST_DONE);

endmodule
